// File: rtl/pattern_ntsc_source.sv
// pattern_ntsc_source: synthetic YCrCb pixel-pair source used in place
// of the NTSC capture front end for simulation and board bring-up.

module pattern_ntsc_source #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int DIV      = 4,
   parameter int X_W      = 10,
   parameter int Y_W      = 9
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic [1:0]     mode,
   output logic [35:0]    ntsc_pixels,
   output logic           ntsc_flag,
   output logic [X_W-1:0] pixel_x,
   output logic [Y_W-1:0] pixel_y,
   output logic           line_flag,
   output logic           frame_flag
);

   localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(DIV - 1);
   localparam logic [X_W-1:0]  X_LAST   = X_W'(H_ACTIVE - 2);
   localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(V_ACTIVE - 1);
   localparam logic [X_W-1:0]  BAR_LAST = X_W'(H_ACTIVE / 16 - 1);

   localparam logic [17:0] WHITE = {8'd235, 5'd16, 5'd16};
   localparam logic [17:0] BLACK = {8'd16, 5'd16, 5'd16};

   typedef enum logic [1:0] {
      PAT_RAMP  = 2'd0,
      PAT_GRAD  = 2'd1,
      PAT_BARS  = 2'd2,
      PAT_CHECK = 2'd3
   } pat_e;

   logic [PH_W-1:0] phase;
   logic [X_W-1:0]  x;
   logic [Y_W-1:0]  y;
   logic [7:0]      ramp;
   logic [X_W-1:0]  bar_cnt;
   logic [2:0]      bar_idx;
   pat_e            mode_q;

   logic            emit;
   logic            x_last;
   logic            y_last;
   logic            origin;
   pat_e            cur_mode;
   logic [7:0]      x_lo;
   logic [17:0]     pix0;
   logic [17:0]     pix1;

   function automatic logic [17:0] bar_colour(input logic [2:0] idx);
      logic [17:0] c;
      c = BLACK;
      unique case (idx)
         3'd0: c = WHITE;
         3'd1: c = {8'd210, 5'd18, 5'd2};
         3'd2: c = {8'd170, 5'd2,  5'd21};
         3'd3: c = {8'd145, 5'd4,  5'd7};
         3'd4: c = {8'd106, 5'd28, 5'd25};
         3'd5: c = {8'd81,  5'd30, 5'd11};
         3'd6: c = {8'd41,  5'd14, 5'd30};
         3'd7: c = BLACK;
      endcase
      return c;
   endfunction

   // Pattern lookup from the current raster position and ramp value.
   always_comb begin
      emit     = enable && (phase == '0);
      x_last   = (x == X_LAST);
      y_last   = (y == Y_LAST);
      origin   = (x == '0) && (y == '0);
      cur_mode = origin ? pat_e'(mode) : mode_q;
      x_lo     = x[7:0];
      pix0     = BLACK;
      pix1     = BLACK;
      unique case (cur_mode)
         PAT_RAMP: begin
            pix0 = {ramp, 10'd0};
            pix1 = {ramp, 10'd0};
         end
         PAT_GRAD: begin
            pix0 = {x_lo, 5'd16, 5'd16};
            pix1 = {x_lo + 8'd1, 5'd16, 5'd16};
         end
         PAT_BARS: begin
            pix0 = bar_colour(bar_idx);
            pix1 = bar_colour(bar_idx);
         end
         PAT_CHECK: begin
            pix0 = (x[5] ^ y[5]) ? WHITE : BLACK;
            pix1 = (x[5] ^ y[5]) ? WHITE : BLACK;
         end
      endcase
   end

   // Cadence divider: one pair every DIV enabled cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= '0;
      end else if (enable) begin
         phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end
   end

   // Raster, ramp, bar counter and latched mode step once per pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         x       <= '0;
         y       <= '0;
         ramp    <= '0;
         bar_cnt <= '0;
         bar_idx <= '0;
         mode_q  <= PAT_RAMP;
      end else if (emit) begin
         ramp   <= ramp + 8'd1;
         mode_q <= cur_mode;
         if (x_last) begin
            x       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            y       <= y_last ? '0 : y + Y_W'(1);
         end else begin
            x <= x + X_W'(2);
            if (bar_cnt == BAR_LAST) begin
               bar_cnt <= '0;
               bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_cnt <= bar_cnt + X_W'(1);
            end
         end
      end
   end

   // Output registers: data holds between pairs, markers are one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         ntsc_pixels <= '0;
         ntsc_flag   <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         line_flag   <= 1'b0;
         frame_flag  <= 1'b0;
      end else begin
         ntsc_flag  <= emit;
         line_flag  <= emit && x_last;
         frame_flag <= emit && x_last && y_last;
         if (emit) begin
            ntsc_pixels <= {pix0, pix1};
            pixel_x     <= x;
            pixel_y     <= y;
         end
      end
   end

endmodule

// File: tb/tb_pattern_ntsc_source.sv
// tb_pattern_ntsc_source: scoreboard bench for the synthetic NTSC
// source on a reduced 64x40 raster.

module tb_pattern_ntsc_source;

   localparam int H     = 64;
   localparam int V     = 40;
   localparam int DIV   = 4;
   localparam int X_W   = 10;
   localparam int Y_W   = 9;
   localparam int PPL   = H / 2;
   localparam int FRAME = PPL * V;

   typedef struct packed {
      logic [35:0]    pix;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic           lf;
      logic           ff;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset;
   logic           enable;
   logic [1:0]     mode;
   logic [35:0]    ntsc_pixels;
   logic           ntsc_flag;
   logic [X_W-1:0] pixel_x;
   logic [Y_W-1:0] pixel_y;
   logic           line_flag;
   logic           frame_flag;

   exp_t q[$];
   exp_t cur_exp;
   logic exp_flag;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   mphase;
   int   npairs;
   int   fmode;

   pattern_ntsc_source #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .DIV      (DIV),
      .X_W      (X_W),
      .Y_W      (Y_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .mode        (mode),
      .ntsc_pixels (ntsc_pixels),
      .ntsc_flag   (ntsc_flag),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .line_flag   (line_flag),
      .frame_flag  (frame_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [17:0] yc(input int yv, input int cr,
                                      input int cb);
      return {8'(yv), 5'(cr), 5'(cb)};
   endfunction

   function automatic logic [17:0] bar_ref(input int b);
      case (b)
         0:       return yc(235, 16, 16);
         1:       return yc(210, 18, 2);
         2:       return yc(170, 2, 21);
         3:       return yc(145, 4, 7);
         4:       return yc(106, 28, 25);
         5:       return yc(81, 30, 11);
         6:       return yc(41, 14, 30);
         default: return yc(16, 16, 16);
      endcase
   endfunction

   // Predicts what the coming clock edge should register.
   task automatic model_step();
      int          idx;
      int          ex;
      int          ey;
      logic [17:0] p0;
      logic [17:0] p1;
      exp_t        e;
      exp_flag = 1'b0;
      if (reset) begin
         mphase  = 0;
         npairs  = 0;
         fmode   = 0;
         cur_exp = '0;
         q.delete();
         return;
      end
      if (!enable) return;
      if (mphase == 0) begin
         idx = npairs % FRAME;
         ex  = 2 * (idx % PPL);
         ey  = idx / PPL;
         if (idx == 0) fmode = int'(mode);
         case (fmode)
            0: begin
               p0 = {8'(npairs % 256), 10'd0};
               p1 = p0;
            end
            1: begin
               p0 = yc(ex % 256, 16, 16);
               p1 = yc((ex + 1) % 256, 16, 16);
            end
            2: begin
               p0 = bar_ref(ex / (H / 8));
               p1 = p0;
            end
            default: begin
               if (((ex / 32) % 2) != ((ey / 32) % 2))
                  p0 = yc(235, 16, 16);
               else
                  p0 = yc(16, 16, 16);
               p1 = p0;
            end
         endcase
         e.pix = {p0, p1};
         e.x   = X_W'(ex);
         e.y   = Y_W'(ey);
         e.lf  = (ex == H - 2);
         e.ff  = (ex == H - 2) && (ey == V - 1);
         q.push_back(e);
         exp_flag = 1'b1;
         npairs++;
      end
      mphase = (mphase + 1) % DIV;
   endtask

   task automatic check_outputs();
      if (exp_flag && q.size() > 0) cur_exp = q.pop_front();
      check("flags", 64'({ntsc_flag, line_flag, frame_flag}),
            64'({exp_flag, exp_flag & cur_exp.lf, exp_flag & cur_exp.ff}));
      if (exp_flag) begin
         check("pixels", 64'(ntsc_pixels), 64'(cur_exp.pix));
         check("pixel_x", 64'(pixel_x), 64'(cur_exp.x));
         check("pixel_y", 64'(pixel_y), 64'(cur_exp.y));
      end else begin
         check("hold", 64'({ntsc_pixels, pixel_x, pixel_y}),
               64'({cur_exp.pix, cur_exp.x, cur_exp.y}));
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run_to(input int tx, input int ty);
      int k;
      bit hit;
      k   = 0;
      hit = 1'b0;
      while (!hit && k < 20000) begin
         step();
         k++;
         hit = exp_flag && (cur_exp.x == X_W'(tx)) &&
               (cur_exp.y == Y_W'(ty));
      end
      if (!hit) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_to: pair (%0d,%0d) not reached in bound",
                  tx, ty);
      end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      mode   = 2'd0;
      repeat (3) step();
      reset = 1'b0;
      run_to(0, 20);
      mode = 2'd2;
      run_to(H - 2, V - 1);
      run_to(H - 2, 0);
      run_to(0, 5);
      mode = 2'd3;
      run_to(H - 2, V - 1);
      run_to(40, 3);
      enable = 1'b0;
      repeat (10) step();
      enable = 1'b1;
      repeat (600) begin
         enable = ($urandom_range(0, 3) != 0);
         step();
      end
      enable = 1'b1;
      run_to(32, 32);
      run_to(0, 34);
      mode  = 2'd1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      run_to(H - 2, 2);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_ntsc_source.md
# pattern_ntsc_source

Parametrised synthetic video source that stands in for the NTSC capture front end. It emits packed YCrCb pixel pairs on a fixed cadence with a data-valid strobe, a pixel position, and line/frame markers. It supports four selectable test patterns, a pause input, and configurable raster size and output rate. It feeds the frame-buffer writer and object-recognition paths in simulation and bring-up when no camera is connected.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line; must be even and divisible by 16.
- `V_ACTIVE`, 480: active lines per frame.
- `DIV`, 4: clocks per emitted pair; must be ≥ 1.
- `X_W`, 10: width of `pixel_x`.
- `Y_W`, 9: width of `pixel_y`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `enable` in 1: when low, generation pauses and position holds.
- `mode` in 2: pattern select. 0 = ramp, 1 = horizontal gradient, 2 = colour bars, 3 = checkerboard.
- `ntsc_pixels` out 36: pixel pair. [35:18] = pixel at `pixel_x`; [17:0] = pixel at `pixel_x`+1. Each pixel is {Y[7:0], Cr[4:0], Cb[4:0]}.
- `ntsc_flag` out 1: one-cycle strobe; `ntsc_pixels`, `pixel_x` and `pixel_y` are valid in this cycle.
- `pixel_x` out X_W: x of the first pixel in the pair (always even).
- `pixel_y` out Y_W: line number.
- `line_flag` out 1: high with the strobe of the last pair of each line.
- `frame_flag` out 1: high with the strobe of the last pair of each frame.

## Operation
- Phase counter runs 0..DIV-1 and wraps; it advances only while `enable`=1.
- A pair is emitted on any edge where phase==0 and `enable`=1. That edge registers the outputs and sets `ntsc_flag`=1 for one cycle.
- Position update after each emission:
  - x += 2.
  - If x == H_ACTIVE-2: x → 0 and y += 1.
  - If additionally y == V_ACTIVE-1: y → 0.
- `line_flag` and `frame_flag` are registered alongside the pair they mark. `frame_flag` implies `line_flag`.
- Mode latching:
  - The pair at (0,0) uses the live `mode` input and stores it in `mode_q`.
  - All other pairs use `mode_q`.
  - Mode changes therefore take effect only at frame start.
- Ramp counter: 8 bits, increments once per emitted pair in every mode, wraps at 256.
- Patterns (Cr/Cb value 16 = neutral):
  - 0 ramp: both pixels {ramp, 0, 0}.
  - 1 gradient: pixel 0 {x[7:0], 16, 16}; pixel 1 {(x+1)[7:0], 16, 16}.
  - 2 colour bars: 8 bars, each H_ACTIVE/8 pixels wide; bar index comes from a per-line counter, no divider. Both pixels use the same bar (bar width is even). Bars 0..7 = white {235,16,16}, yellow {210,18,2}, cyan {170,2,21}, green {145,4,7}, magenta {106,28,25}, red {81,30,11}, blue {41,14,30}, black {16,16,16}.
  - 3 checkerboard: x[5]^y[5] = 1 gives white {235,16,16}; otherwise black {16,16,16}. Both pixels share the value.
- `enable` low:
  - Phase, x, y, ramp and `mode_q` hold.
  - `ntsc_flag`, `line_flag` and `frame_flag` are 0.
  - `ntsc_pixels`, `pixel_x` and `pixel_y` hold their last values.
- Reset (including mid-frame):
  - Phase, x, y, ramp and `mode_q` → 0.
  - All outputs → 0.
  - The next frame restarts at (0,0).
  - Reset takes priority over `enable`.

## Timing
- Reset values: `ntsc_pixels`=0, `ntsc_flag`=0, `pixel_x`=0, `pixel_y`=0, `line_flag`=0, `frame_flag`=0.
- With `enable`=1 continuously, the first edge after reset deasserts registers pair (0,0). `ntsc_flag` is high in the following cycle and then every DIV cycles.
- DIV=1: `ntsc_flag` is high every cycle.
- Frame length = H_ACTIVE/2 × V_ACTIVE pairs = 153600 pairs at the defaults.
- Pattern computation is single-cycle from the registered x, y and ramp values. Outputs are fully registered, with no combinational path from inputs to outputs.

## Test plan
- Ramp and cadence: reset, then `mode`=0, `enable`=1, DIV=4 → `ntsc_flag` in cycles 1, 5, 9, …; first pair 36'h0 at (0,0); second pair Y=1 in both halves at x=2.
- Line wrap: after 320 pairs, `pixel_x`=638 with `line_flag`=1 and `frame_flag`=0 → next pair at x=0, y=1.
- Frame wrap: pair 153600 is at (638,479) with `line_flag`=`frame_flag`=1 → next pair at (0,0) with ramp Y=0 (153600 mod 256 = 0).
- Mode latching:
  - Switch `mode` 0→2 at y=100 → ramp continues to frame end.
  - Next frame: pair x=0 = {235,16,16} twice; pair x=80 = {210,18,2}; pair x=560 = {16,16,16}.
- Checkerboard, `mode`=3:
  - (0,0) → black.
  - x=32, y=0 → white.
  - x=32, y=32 → black.
- Pause and reset:
  - Drop `enable` for 10 cycles at x=100 → no strobes, `pixel_x` holds at 100; on resume the next pair is x=102.
  - Assert `reset` for 1 cycle mid-frame → all outputs 0; generation restarts at (0,0) with ramp 0.
